// File: rtl/trig_capture_ctrl.sv
// Trigger-qualified capture stage: writes AD samples into a circular RAM, finds a
// hysteresis-qualified level crossing, freezes a pre/post-trigger frame and replays it in order.
module trig_capture_ctrl #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 10,
    parameter int PRETRIG = 256,
    parameter int HYST    = 4,
    parameter int AUTO_TO = 65535
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              samp_clk,
    input  logic [DATA_W-1:0] ad_data,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic              auto_en,
    input  logic              arm,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              trig_auto,
    output logic [2:0]        state
);
    // state       | meaning
    // IDLE (0)    | no capture in progress, RAM not written
    // PRE (1)     | collecting the PRETRIG samples that precede any trigger
    // WAIT_TRIG(2)| writing, looking for a qualified crossing or auto timeout
    // POST (3)    | writing the samples that follow the trigger sample
    // DONE (4)    | frame frozen, readable via rd_en

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int AC_W  = (AUTO_TO < 2) ? 1 : $clog2(AUTO_TO + 1);
    localparam logic [DATA_W:0] HYST_X = (DATA_W + 1)'(HYST);
    localparam logic [DATA_W:0] MAX_X  = {1'b0, {DATA_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRE       = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_POST      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t            st;
    logic              samp_s1, samp_s2, samp_s3;
    logic              stb;
    logic [DATA_W-1:0] samp_q;
    logic              wr_pend;
    logic [ADDR_W-1:0] wp, rp, taddr;
    logic [ADDR_W-1:0] pre_cnt, post_cnt;
    logic [AC_W-1:0]   auto_cnt;
    logic              flag_lo, flag_hi;

    logic              writing, re;
    logic [DATA_W:0]   lvl_x, samp_x, lo_th, hi_sum, hi_th;
    logic              at_lo, at_hi, hit_rise, hit_fall, hit, auto_hit;

    logic [DATA_W-1:0] mem [DEPTH];

    assign stb     = samp_s2 & ~samp_s3;
    assign writing = wr_pend && !arm &&
                     (st == S_PRE || st == S_WAIT_TRIG || st == S_POST);
    assign re      = (st == S_DONE) && rd_en && !arm;

    // Thresholds saturate at the code range so a level near either rail still arms.
    assign lvl_x  = {1'b0, trig_level};
    assign samp_x = {1'b0, samp_q};
    assign lo_th  = (lvl_x < HYST_X) ? '0 : (lvl_x - HYST_X);
    assign hi_sum = lvl_x + HYST_X;
    assign hi_th  = (hi_sum > MAX_X) ? MAX_X : hi_sum;
    assign at_lo  = (samp_x <= lo_th);
    assign at_hi  = (samp_x >= hi_th);

    assign hit_rise = !trig_slope && flag_lo && (samp_q >= trig_level);
    assign hit_fall =  trig_slope && flag_hi && (samp_q <= trig_level);
    assign hit      = hit_rise || hit_fall;
    assign auto_hit = auto_en && (AUTO_TO != 0) && (auto_cnt == AC_W'(1));

    assign state = st;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            st        <= S_IDLE;
            samp_s1   <= 1'b0;
            samp_s2   <= 1'b0;
            samp_s3   <= 1'b0;
            samp_q    <= '0;
            wr_pend   <= 1'b0;
            wp        <= '0;
            rp        <= '0;
            taddr     <= '0;
            pre_cnt   <= '0;
            post_cnt  <= '0;
            auto_cnt  <= '0;
            flag_lo   <= 1'b0;
            flag_hi   <= 1'b0;
            done      <= 1'b0;
            trig_auto <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            samp_s1  <= samp_clk;
            samp_s2  <= samp_s1;
            samp_s3  <= samp_s2;
            rd_valid <= re;

            if (stb && !arm) begin
                samp_q  <= ad_data;
                wr_pend <= 1'b1;
            end else begin
                wr_pend <= 1'b0;
            end

            if (writing) wp <= wp + 1'b1;
            if (re)      rp <= rp + 1'b1;

            if (arm) begin
                st        <= S_PRE;
                done      <= 1'b0;
                trig_auto <= 1'b0;
                pre_cnt   <= ADDR_W'(PRETRIG);
                post_cnt  <= '0;
                auto_cnt  <= AC_W'(AUTO_TO);
                flag_lo   <= 1'b0;
                flag_hi   <= 1'b0;
            end else if (writing) begin
                if (at_lo)                                flag_lo <= 1'b1;
                else if (st == S_WAIT_TRIG && hit_rise)   flag_lo <= 1'b0;
                if (at_hi)                                flag_hi <= 1'b1;
                else if (st == S_WAIT_TRIG && hit_fall)   flag_hi <= 1'b0;

                case (st)
                    S_PRE: begin
                        pre_cnt <= pre_cnt - 1'b1;
                        if (pre_cnt == ADDR_W'(1)) begin
                            st       <= S_WAIT_TRIG;
                            auto_cnt <= AC_W'(AUTO_TO);
                        end
                    end
                    S_WAIT_TRIG: begin
                        if (hit || auto_hit) begin
                            taddr     <= wp;
                            post_cnt  <= ADDR_W'(DEPTH - PRETRIG - 1);
                            trig_auto <= !hit;
                            st        <= S_POST;
                        end else if (auto_cnt > AC_W'(1)) begin
                            // holds at 1 so enabling auto later still forces promptly
                            auto_cnt <= auto_cnt - 1'b1;
                        end
                    end
                    S_POST: begin
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == ADDR_W'(1)) begin
                            st   <= S_DONE;
                            done <= 1'b1;
                            rp   <= taddr - ADDR_W'(PRETRIG);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (writing) mem[wp] <= samp_q;
    end

    // Read port register with synchronous reset keeps the block-RAM mapping.
    always_ff @(posedge sys_clk) begin
        if (rst)     rd_data <= '0;
        else if (re) rd_data <= mem[rp];
    end

endmodule

// File: tb/tb_trig_capture_ctrl.sv
// Directed bench for trig_capture_ctrl: sample-list model of the frame plus per-cycle compare.
module tb_trig_capture_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int PRE   = 8;
    localparam int HY    = 4;
    localparam int ATO   = 16;

    logic          sys_clk = 1'b0;
    logic          rst = 1'b1;
    logic          samp_clk = 1'b0;
    logic [DW-1:0] ad_data = '0;
    logic [DW-1:0] trig_level = 8'd128;
    logic          trig_slope = 1'b0;
    logic          auto_en = 1'b0;
    logic          arm = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          done;
    logic          trig_auto;
    logic [2:0]    state;

    trig_capture_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .PRETRIG(PRE), .HYST(HY), .AUTO_TO(ATO)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .samp_clk(samp_clk), .ad_data(ad_data),
        .trig_level(trig_level), .trig_slope(trig_slope), .auto_en(auto_en),
        .arm(arm), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .trig_auto(trig_auto), .state(state)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Model: the list of samples written since arm; the frame is a window of that list.
    bit             m_armed = 0, m_lo = 0, m_hi = 0, m_done = 0, m_auto = 0;
    int             m_trig = -1;
    logic [DW-1:0]  m_q[$];
    logic [DW-1:0]  m_frame[$];
    bit             exp_rv = 0;
    logic [DW-1:0]  exp_rd = '0;
    int             rd_idx = 0;
    bit             cmp_on = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_state();
        if (!m_armed)             return 0;
        if (m_done)               return 4;
        if (m_q.size() < PRE)     return 1;
        if (m_trig < 0)           return 2;
        return 3;
    endfunction

    function automatic void model_arm();
        m_armed = 1; m_q.delete(); m_frame.delete();
        m_trig = -1; m_lo = 0; m_hi = 0; m_done = 0; m_auto = 0; rd_idx = 0;
    endfunction

    function automatic void model_write(input logic [DW-1:0] s);
        int n, lvl, lo_th, hi_th;
        if (!m_armed || m_done) return;
        lvl   = int'(trig_level);
        lo_th = (lvl - HY < 0) ? 0 : lvl - HY;
        hi_th = (lvl + HY > 255) ? 255 : lvl + HY;
        n = m_q.size();
        m_q.push_back(s);
        if (m_trig < 0 && n >= PRE) begin
            if ((!trig_slope && m_lo && int'(s) >= lvl) ||
                ( trig_slope && m_hi && int'(s) <= lvl))
                m_trig = n;
            else if (auto_en && (n - PRE + 1) >= ATO) begin
                m_trig = n;
                m_auto = 1;
            end
        end
        if (int'(s) <= lo_th) m_lo = 1;
        if (int'(s) >= hi_th) m_hi = 1;
        if (m_trig >= 0 && m_q.size() == m_trig + DEPTH - PRE) begin
            m_done = 1;
            for (int i = m_trig - PRE; i < m_trig + DEPTH - PRE; i++) m_frame.push_back(m_q[i]);
        end
    endfunction

    always @(posedge sys_clk) begin
        #1;
        if (cmp_on) begin
            check("state", int'(state), exp_state());
            check("done", int'(done), int'(m_done));
            check("trig_auto", int'(trig_auto), int'(m_auto));
            check("rd_valid", int'(rd_valid), int'(exp_rv));
            if (exp_rv) check("rd_data", int'(rd_data), int'(exp_rd));
        end
    end

    task automatic push(input logic [DW-1:0] v);
        @(negedge sys_clk); ad_data = v; samp_clk = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk); samp_clk = 1'b0;
        @(negedge sys_clk); model_write(v);
        @(negedge sys_clk);
    endtask

    task automatic do_arm(input bit with_rd);
        @(negedge sys_clk); arm = 1'b1; rd_en = with_rd; model_arm(); exp_rv = 0;
        @(negedge sys_clk); arm = 1'b0; rd_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge sys_clk); rst = 1'b1; m_armed = 0; m_done = 0; m_auto = 0; exp_rv = 0;
        @(negedge sys_clk); rst = 1'b0;
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            rd_en  = 1'b1;
            exp_rv = m_done;
            if (m_done) begin
                exp_rd = m_frame[rd_idx % DEPTH];
                rd_idx++;
            end
        end
        @(negedge sys_clk); rd_en = 1'b0; exp_rv = 0;
    endtask

    task automatic fill_until_done(input logic [DW-1:0] start, input bit ramp);
        logic [DW-1:0] v;
        v = start;
        for (int i = 0; i < 300 && !m_done; i++) begin
            push(v);
            if (ramp) v = v + 1'b1;
        end
    endtask

    initial begin
        int bad;
        repeat (3) @(negedge sys_clk);
        check("rst_state", int'(state), 0);
        check("rst_done", int'(done), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_trig_auto", int'(trig_auto), 0);
        rst = 1'b0;
        cmp_on = 1;

        // 1: rising ramp, level 128
        trig_level = 8'd128; trig_slope = 1'b0; auto_en = 1'b0;
        do_arm(0);
        fill_until_done(8'd0, 1);
        check("t1_done", int'(done), 1);
        check("t1_taddr_val", m_trig, 128);
        check("t1_first", int'(m_frame[0]), 120);
        check("t1_at_pre", int'(m_frame[PRE]), 128);
        check("t1_last", int'(m_frame[DEPTH-1]), 183);
        read_n(DEPTH + 4);

        // arm together with rd_en: arm wins
        do_arm(1);
        check("arm_rd_state", int'(state), 1);

        // 2: hysteresis
        for (int i = 0; i < PRE; i++) push(8'd126);
        check("t2_wait", int'(state), 2);
        push(8'd126); push(8'd129); push(8'd127); push(8'd129);
        check("t2_no_trig", int'(state), 2);
        check("t2_model_no_trig", m_trig, -1);
        push(8'd120); push(8'd130);
        check("t2_trig", int'(state), 3);
        check("t2_trig_idx", m_trig, 13);
        fill_until_done(8'd130, 0);
        check("t2_at_pre", int'(m_frame[PRE]), 130);
        check("t2_before", int'(m_frame[PRE-1]), 120);
        read_n(DEPTH);

        // 3: falling, level 150
        trig_level = 8'd150; trig_slope = 1'b1;
        do_arm(0);
        for (int i = 0; i < 4; i++) begin push(8'd200); push(8'd100); end
        check("t3_pre_ignored", int'(state), 2);
        push(8'd200);
        check("t3_still_wait", int'(state), 2);
        push(8'd100);
        check("t3_trig", int'(state), 3);
        check("t3_trig_idx", m_trig, 9);
        fill_until_done(8'd100, 0);
        check("t3_at_pre", int'(m_frame[PRE]), 100);
        read_n(16);

        // 4: auto trigger on constant 50
        trig_level = 8'd128; trig_slope = 1'b0; auto_en = 1'b1;
        do_arm(0);
        fill_until_done(8'd50, 0);
        check("t4_trig_idx", m_trig, PRE + ATO - 1);
        check("t4_trig_auto", int'(trig_auto), 1);
        check("t4_done", int'(done), 1);
        bad = 0;
        foreach (m_frame[i]) if (m_frame[i] != 8'd50) bad++;
        check("t4_frame_all50", bad, 0);
        read_n(DEPTH);
        auto_en = 1'b0;

        // 5: re-arm in POST, reads outside DONE ignored
        do_arm(0);
        for (int v = 0; v < 140; v++) push(8'(v));
        check("t5_post", int'(state), 3);
        read_n(3);
        do_arm(0);
        check("t5_rearm_state", int'(state), 1);
        check("t5_rearm_done", int'(done), 0);
        read_n(2);
        fill_until_done(8'd0, 1);
        check("t5_first", int'(m_frame[0]), 120);
        read_n(DEPTH);

        // 6: reset while waiting for trigger, then strobes without arm
        do_arm(0);
        for (int i = 0; i < PRE + 1; i++) push(8'd126);
        check("t6_wait", int'(state), 2);
        do_reset();
        check("t6_state", int'(state), 0);
        check("t6_done", int'(done), 0);
        push(8'd10); push(8'd200); push(8'd10);
        check("t6_idle", int'(state), 0);
        read_n(2);

        cmp_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
